// File: rtl/count_requester.sv
// count_requester: initiator side of the start/done/count four-phase handshake.
// Runs the counter RUNS times per go, summing captured counts, with a wait timeout.
module count_requester #(
    parameter int RUNS    = 4,
    parameter int COUNT_W = 4,
    parameter int SUM_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               done,
    input  logic [COUNT_W-1:0] count,
    output logic               start,
    output logic               busy,
    output logic [COUNT_W-1:0] last_count,
    output logic [SUM_W-1:0]   result_sum,
    output logic [7:0]         runs_done,
    output logic               finished,
    output logic               timeout_err
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 2);
    localparam logic [7:0] RUNS_L = 8'(RUNS);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        NEXT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SUM_W-1:0]  count_ext;
    logic              wait_expired;

    assign count_ext    = SUM_W'(count);
    // the edge that would make the wait reach TIMEOUT-1 cycles
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            start       <= 1'b0;
            busy        <= 1'b0;
            last_count  <= '0;
            result_sum  <= '0;
            runs_done   <= '0;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            finished <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go && !done) begin
                        state       <= REQ;
                        start       <= 1'b1;
                        busy        <= 1'b1;
                        wait_cnt    <= '0;
                        result_sum  <= '0;
                        runs_done   <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                REQ: begin
                    if (done) begin
                        state      <= RELEASE;
                        start      <= 1'b0;
                        wait_cnt   <= '0;
                        last_count <= count;
                        result_sum <= result_sum + count_ext;
                        runs_done  <= runs_done + 8'd1;
                    end else if (wait_expired) begin
                        state       <= IDLE;
                        start       <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!done) begin
                        state <= NEXT;
                    end else if (wait_expired) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                NEXT: begin
                    if (runs_done == RUNS_L) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                    end else begin
                        state    <= REQ;
                        start    <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    start <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_requester.sv
// tb_count_requester: directed scenarios against a behavioural reference
// of the run sequencer, plus hand-computed end-of-scenario values.
module tb_count_requester;

    localparam int RUNS = 4;
    localparam int CW   = 4;
    localparam int SW   = 5;
    localparam int TO   = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          go    = 1'b0;
    logic          done  = 1'b0;
    logic [CW-1:0] count = '0;

    logic          start;
    logic          busy;
    logic [CW-1:0] last_count;
    logic [SW-1:0] result_sum;
    logic [7:0]    runs_done;
    logic          finished;
    logic          timeout_err;

    count_requester #(
        .RUNS(RUNS),
        .COUNT_W(CW),
        .SUM_W(SW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .done(done),
        .count(count),
        .start(start),
        .busy(busy),
        .last_count(last_count),
        .result_sum(result_sum),
        .runs_done(runs_done),
        .finished(finished),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 waiting for done high, 2 waiting for done low, 3 decide
    int unsigned   cyc = 0;
    int unsigned   entry = 0;
    int            ph = 0;
    int unsigned   m_total = 0;
    int            m_runs = 0;
    logic [CW-1:0] m_last = '0;
    bit            m_fin = 0;
    bit            m_terr = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph = 0;
            m_total = 0;
            m_runs = 0;
            m_last = '0;
            m_fin = 0;
            m_terr = 0;
        end else begin
            cyc++;
            m_fin = 0;
            case (ph)
                0: if (go && !done) begin
                    ph = 1;
                    entry = cyc;
                    m_total = 0;
                    m_runs = 0;
                    m_terr = 0;
                end
                1: if (done) begin
                    m_last = count;
                    m_total += count;
                    m_runs++;
                    ph = 2;
                    entry = cyc;
                end else if (cyc - entry == TO - 1) begin
                    ph = 0;
                    m_terr = 1;
                end
                2: if (!done) begin
                    ph = 3;
                end else if (cyc - entry == TO - 1) begin
                    ph = 0;
                    m_terr = 1;
                end
                default: if (m_runs == RUNS) begin
                    ph = 0;
                    m_fin = 1;
                end else begin
                    ph = 1;
                    entry = cyc;
                end
            endcase
        end
    end

    // ---------------- counter responder ----------------
    // mode 0 normal, 1 never responds, 2 done sticks high, 3 manual
    int            rmode = 3;
    int            rdelay = 2;
    int            rcnt = 0;
    bit            mdone = 0;
    logic [CW-1:0] vals [4];

    always @(negedge clk) begin
        case (rmode)
            0, 2: begin
                if (start) begin
                    if (!done) begin
                        rcnt++;
                        if (rcnt >= rdelay) begin
                            done = 1'b1;
                            count = vals[m_runs % 4];
                        end
                    end
                end else begin
                    rcnt = 0;
                    if (rmode == 0) begin
                        done = 1'b0;
                        count = 4'hA;
                    end
                end
            end
            1: begin
                done = 1'b0;
                rcnt = 0;
            end
            default: begin
                done = mdone;
                rcnt = 0;
            end
        endcase
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;
    int n_fin = 0;
    int n_rise = 0;
    int n_hi = 0;
    bit prev_start = 0;
    int r0, f0, h0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    endtask

    task automatic tick();
        logic [20:0] exp_v;
        logic [20:0] act_v;
        @(posedge clk);
        #2;
        exp_v = {ph == 1, ph != 0, m_last, SW'(m_total), 8'(m_runs),
                 m_fin, m_terr};
        act_v = {start, busy, last_count, result_sum, runs_done,
                 finished, timeout_err};
        chk("cycle", 32'(act_v), 32'(exp_v));
        if (finished === 1'b1) n_fin++;
        if (start === 1'b1 && !prev_start) n_rise++;
        if (start === 1'b1) n_hi++;
        prev_start = (start === 1'b1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // sel 0: wait for finished, sel 1: wait for timeout_err
    task automatic wait_flag(input int sel, input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (sel == 0 && finished === 1'b1) seen = 1;
            if (sel == 1 && timeout_err === 1'b1) seen = 1;
        end
        chk(sel == 0 ? "finished_seen" : "timeout_seen", 32'(seen), 1);
    endtask

    task automatic set_vals(input int a, input int b, input int c,
                            input int d);
        vals[0] = CW'(a);
        vals[1] = CW'(b);
        vals[2] = CW'(c);
        vals[3] = CW'(d);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        set_vals(0, 0, 0, 0);
        ticks(2);
        chk("reset_outputs", 32'({start, busy, last_count, result_sum,
            runs_done, finished, timeout_err}), 0);
        reset = 1'b1;
        ticks(2);

        // nominal: 3+5+7+9
        rmode = 0;
        rdelay = 2;
        set_vals(3, 5, 7, 9);
        r0 = n_rise;
        f0 = n_fin;
        pulse_go();
        wait_flag(0, 60);
        ticks(2);
        chk("nom_sum", 32'(result_sum), 24);
        chk("nom_runs", 32'(runs_done), 4);
        chk("nom_last", 32'(last_count), 9);
        chk("nom_fin_pulses", 32'(n_fin - f0), 1);
        chk("nom_start_pulses", 32'(n_rise - r0), 4);
        chk("nom_terr", 32'(timeout_err), 0);

        // wrap: 60 mod 32
        set_vals(15, 15, 15, 15);
        pulse_go();
        wait_flag(0, 60);
        ticks(1);
        chk("wrap_sum", 32'(result_sum), 28);
        chk("wrap_runs", 32'(runs_done), 4);

        // go while done high in IDLE
        rmode = 3;
        mdone = 1;
        ticks(2);
        r0 = n_rise;
        go = 1'b1;
        ticks(2);
        go = 1'b0;
        ticks(1);
        chk("ign_go_start", 32'(n_rise - r0), 0);
        chk("ign_go_busy", 32'(busy), 0);
        mdone = 0;
        ticks(2);

        // go pulsed mid-run
        rmode = 0;
        set_vals(1, 2, 3, 4);
        r0 = n_rise;
        pulse_go();
        ticks(3);
        go = 1'b1;
        ticks(2);
        go = 1'b0;
        wait_flag(0, 60);
        ticks(1);
        chk("midgo_sum", 32'(result_sum), 10);
        chk("midgo_pulses", 32'(n_rise - r0), 4);

        // timeout in REQ
        rmode = 1;
        h0 = n_hi;
        f0 = n_fin;
        pulse_go();
        wait_flag(1, 30);
        chk("to_req_start_cycles", 32'(n_hi - h0), 7);
        chk("to_req_start", 32'(start), 0);
        chk("to_req_busy", 32'(busy), 0);
        chk("to_req_no_fin", 32'(n_fin - f0), 0);
        ticks(2);
        rmode = 0;
        set_vals(2, 2, 2, 2);
        ticks(1);
        pulse_go();
        chk("restart_terr", 32'(timeout_err), 0);
        chk("restart_runs", 32'(runs_done), 0);
        chk("restart_start", 32'(start), 1);
        wait_flag(0, 60);
        ticks(1);
        chk("restart_sum", 32'(result_sum), 8);

        // timeout in RELEASE
        rmode = 2;
        set_vals(6, 1, 1, 1);
        pulse_go();
        wait_flag(1, 40);
        chk("to_rel_sum", 32'(result_sum), 6);
        chk("to_rel_runs", 32'(runs_done), 1);
        chk("to_rel_last", 32'(last_count), 6);
        rmode = 0;
        ticks(3);

        // async reset mid-run
        rdelay = 3;
        set_vals(5, 5, 5, 5);
        pulse_go();
        ticks(1);
        chk("pre_reset_start", 32'(start), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({start, busy, last_count,
            result_sum, runs_done, finished, timeout_err}), 0);
        ticks(2);
        reset = 1'b1;
        r0 = n_rise;
        ticks(6);
        chk("post_reset_quiet", 32'(n_rise - r0), 0);
        chk("post_reset_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/count_requester.md
# count_requester

Initiator side of the start/done/count handshake used by the lab counter circuit. On a `go` command it runs the counter `RUNS` times back to back. For each run it:
- raises `start`,
- waits for `done`,
- captures `count`,
- releases `start` and waits for `done` to drop.

It accumulates the captured counts into a running sum and flags a timeout if the counter stops responding. It sits between the top-level control logic and the counter circuit, driving that circuit's `start` and consuming its `done` and `count`.

## Interface
- `RUNS`, default 4: runs per `go` command; legal range 1..255.
- `COUNT_W`, default 4: width of the `count` input.
- `SUM_W`, default 8: width of `result_sum`.
- `TIMEOUT`, default 64: maximum cycles spent waiting in REQ or RELEASE before an error; must be ≥ 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `go`  input  1  command request; sampled only in IDLE.
- `done`  input  1  completion flag from the counter.
- `count`  input  COUNT_W  counter result; valid while `done`=1.
- `start`  output  1  request to the counter; held level (four-phase handshake).
- `busy`  output  1  high in REQ, RELEASE and NEXT.
- `last_count`  output  COUNT_W  most recently captured `count`.
- `result_sum`  output  SUM_W  sum of the counts captured since the last accepted `go`.
- `runs_done`  output  8  runs completed since the last accepted `go`.
- `finished`  output  1  one-cycle pulse when all `RUNS` runs complete.
- `timeout_err`  output  1  sticky timeout flag.

## Operation
- **Reset (`reset`=0):** state=IDLE and every output is 0 (`start`, `busy`, `last_count`, `result_sum`, `runs_done`, `finished`, `timeout_err`). Reset takes effect immediately and asynchronously, including mid-run; `start` drops without waiting for `done`.
- **IDLE:**
  - `go`=1 and `done`=0 → REQ. On the same edge: clear `result_sum`, `runs_done` and `timeout_err`; set `start`=1.
  - `go`=1 while `done`=1 is ignored and not queued.
  - `go` in any other state is ignored.
- **REQ (`start`=1):** wait for `done`=1. On the edge that samples `done`=1:
  - `last_count`←`count`;
  - `result_sum`←`result_sum`+zero-extended `count`, wrapping modulo 2^SUM_W;
  - `runs_done`+1;
  - `start`←0;
  - → RELEASE.
- **RELEASE (`start`=0):** wait for `done`=0, then → NEXT.
- **NEXT:**
  - If `runs_done`==RUNS → IDLE with `finished`=1 for exactly that one cycle.
  - Otherwise → REQ with `start`=1.
- **Timeout:**
  - A wait counter is cleared on every entry to REQ or RELEASE and increments each cycle spent there.
  - If it reaches TIMEOUT-1 without the awaited edge of `done`: `start`←0, `timeout_err`←1, → IDLE.
  - `finished` is not pulsed on a timeout.
  - `result_sum`, `runs_done` and `last_count` keep their values for post-mortem.
- `count` is ignored whenever the block is not in REQ sampling `done`=1.
- A `done` glitch during IDLE or NEXT has no effect, apart from blocking `go` in IDLE as above.

## Timing
- `go` sampled at edge N → `start`=1 and `busy`=1 after edge N.
- `done`=1 sampled at edge M in REQ → `last_count`, `result_sum` and `runs_done` updated and `start`=0 after edge M. Capture latency is 1 cycle.
- `done`=0 sampled at edge K in RELEASE → NEXT after K. Then either REQ with `start`=1 after K+1, or IDLE with `finished`=1 after K+1.
- Minimum period per run, with a counter that responds the cycle after each `start` edge: 4 cycles (REQ, RELEASE, NEXT, plus the response cycle).
- `busy` falls in the same cycle that `finished` pulses, or in the cycle `timeout_err` rises.

## Test plan
- **Nominal run:** RUNS=4; counter model returns counts 3, 5, 7, 9 with 2-cycle response → `start` shows 4 clean high/low pulses, `result_sum`=24, `runs_done`=4, `last_count`=9, `finished` high for exactly one cycle, `timeout_err`=0.
- **Wrap-around:** SUM_W=4, RUNS=3; counts 15, 15, 2 → `result_sum`=0 (32 mod 16), `runs_done`=3, `finished` pulses.
- **Timeout in REQ:** TIMEOUT=8; model never raises `done` → `start` drops 7 cycles after it rose, `timeout_err`=1, state IDLE, no `finished`. A following `go` clears `timeout_err` and restarts at `runs_done`=0.
- **Timeout in RELEASE:** model holds `done`=1 forever after the first capture → `result_sum`=first count, `runs_done`=1, `timeout_err`=1 after TIMEOUT-1 cycles in RELEASE.
- **Ignored go:** `go` pulsed while `done`=1 in IDLE → no `start`. `go` pulsed mid-run → the run sequence and final sum are unchanged.
- **Async reset mid-run:** drive `reset`=0 between clock edges while `start`=1 → `start`, `busy` and all outputs are 0 immediately. After release, nothing happens until a new `go`.
